// File: rtl/icache_pkg.sv
// Shared address/line layout and FSM encoding for the direct-mapped instruction cache.
// Default geometry: 64 lines of 16 bytes; tag = pc[31:10], index = pc[9:4], word = pc[3:2].
package icache_pkg;

    localparam int ADDR_W            = 32;
    localparam int DEF_INDEX_WIDTH   = 6;
    localparam int DEF_OFFSET_WIDTH  = 4;
    localparam int CACHE_LINE_W      = 8 << DEF_OFFSET_WIDTH;

    typedef logic [ADDR_W-1:0]       addr_t;
    typedef logic [CACHE_LINE_W-1:0] cache_line_t;

    // Field ranges of a fetch address for the default geometry.
    localparam int ICACHE_TAG_HI     = 31;
    localparam int ICACHE_TAG_LO     = DEF_INDEX_WIDTH + DEF_OFFSET_WIDTH;
    localparam int ICACHE_INDEX_HI   = DEF_INDEX_WIDTH + DEF_OFFSET_WIDTH - 1;
    localparam int ICACHE_INDEX_LO   = DEF_OFFSET_WIDTH;
    localparam int ICACHE_WORD_HI    = DEF_OFFSET_WIDTH - 1;
    localparam int ICACHE_WORD_LO    = 2;
    localparam int CACHE_TAG_AND_INDEX_HI = 31;
    localparam int CACHE_TAG_AND_INDEX_LO = DEF_OFFSET_WIDTH;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MISS = 1'b1
    } icache_state_e;

endpackage

// File: rtl/icache.sv
// Direct-mapped instruction cache: one-cycle hit response, blocking line fill on miss.
// A flush during a fill lets the fill complete and be written but suppresses the response.
module icache
    import icache_pkg::*;
#(
    parameter int INDEX_WIDTH  = DEF_INDEX_WIDTH,
    parameter int OFFSET_WIDTH = DEF_OFFSET_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rdy,
    input  logic                          valid_from_ifetch,
    input  logic [31:0]                   pc_from_ifetch,
    input  logic                          clear_from_rob,
    output logic                          ready_to_ifetch,
    output logic [31:0]                   inst_to_ifetch,
    output logic                          valid_to_mem,
    output logic [31:0]                   addr_to_mem,
    input  logic                          ready_from_mem,
    input  logic [(8<<OFFSET_WIDTH)-1:0]  data_from_mem,
    output icache_state_e                 debug_state
);

    localparam int LINES  = 1 << INDEX_WIDTH;
    localparam int LINE_W = 8 << OFFSET_WIDTH;
    localparam int TAG_W  = 32 - INDEX_WIDTH - OFFSET_WIDTH;
    localparam int WSEL_W = OFFSET_WIDTH - 2;

    // Handshakes: ifetch holds valid_from_ifetch with a stable pc until it sees the
    // one-cycle ready_to_ifetch pulse; the cache holds valid_to_mem/addr_to_mem until
    // the one-cycle ready_from_mem pulse. rdy=0 freezes every register.

    icache_state_e             state;
    logic                      cancel;
    logic [WSEL_W-1:0]         miss_word;
    logic [LINES-1:0]          line_valid;
    logic [TAG_W-1:0]          tag_mem  [LINES];
    logic [LINE_W-1:0]         data_mem [LINES];

    logic [TAG_W-1:0]          pc_tag;
    logic [INDEX_WIDTH-1:0]    pc_index;
    logic [WSEL_W-1:0]         pc_word;
    logic [TAG_W-1:0]          fill_tag;
    logic [INDEX_WIDTH-1:0]    fill_index;
    logic [LINE_W-1:0]         hit_line;
    logic [31:0]               hit_word;
    logic [31:0]               fill_word;
    logic                      hit;
    logic                      fill_done;

    assign pc_tag     = pc_from_ifetch[31 -: TAG_W];
    assign pc_index   = pc_from_ifetch[OFFSET_WIDTH +: INDEX_WIDTH];
    assign pc_word    = pc_from_ifetch[2 +: WSEL_W];

    // The outstanding fill address doubles as the miss tag/index.
    assign fill_tag   = addr_to_mem[31 -: TAG_W];
    assign fill_index = addr_to_mem[OFFSET_WIDTH +: INDEX_WIDTH];

    assign hit_line   = data_mem[pc_index];
    assign hit_word   = hit_line[32*pc_word +: 32];
    assign fill_word  = data_from_mem[32*miss_word +: 32];
    assign hit        = line_valid[pc_index] && (tag_mem[pc_index] == pc_tag);
    assign fill_done  = !rst && rdy && (state == ST_MISS) && ready_from_mem;

    assign debug_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= ST_IDLE;
            cancel          <= 1'b0;
            miss_word       <= '0;
            line_valid      <= '0;
            ready_to_ifetch <= 1'b0;
            inst_to_ifetch  <= '0;
            valid_to_mem    <= 1'b0;
            addr_to_mem     <= '0;
        end else if (rdy) begin
            case (state)
                ST_IDLE: begin
                    ready_to_ifetch <= 1'b0;
                    // A request seen while the previous response is on the bus is the
                    // same request still held; skipping it avoids a double accept.
                    if (valid_from_ifetch && !clear_from_rob && !ready_to_ifetch) begin
                        if (hit) begin
                            ready_to_ifetch <= 1'b1;
                            inst_to_ifetch  <= hit_word;
                        end else begin
                            state        <= ST_MISS;
                            cancel       <= 1'b0;
                            miss_word    <= pc_word;
                            valid_to_mem <= 1'b1;
                            addr_to_mem  <= {pc_from_ifetch[31:OFFSET_WIDTH],
                                             {OFFSET_WIDTH{1'b0}}};
                        end
                    end
                end
                ST_MISS: begin
                    ready_to_ifetch <= 1'b0;
                    if (ready_from_mem) begin
                        line_valid[fill_index] <= 1'b1;
                        valid_to_mem           <= 1'b0;
                        state                  <= ST_IDLE;
                        cancel                 <= 1'b0;
                        if (!cancel && !clear_from_rob) begin
                            ready_to_ifetch <= 1'b1;
                            inst_to_ifetch  <= fill_word;
                        end
                    end else if (clear_from_rob) begin
                        cancel <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Tag and data arrays carry no reset; line_valid alone guards them.
    always_ff @(posedge clk) begin
        if (fill_done) begin
            tag_mem[fill_index]  <= fill_tag;
            data_mem[fill_index] <= data_from_mem;
        end
    end

endmodule
